// File: rtl/peripheral_mpram_axi4_master.sv
// peripheral_mpram_axi4_master
// AXI4 manager that converts a single-outstanding native request port into one
// AXI4 INCR transaction at a time (AR/R for reads, AW/W/B for writes).
// Optional feature macro: PERIPHERAL_MPRAM_AXI4_MASTER_BURST_EN
//   defined   : len_i is honoured (1-256 beats)
//   undefined : every transaction is a single beat, axi_*_len = 0
module peripheral_mpram_axi4_master #(
  parameter int AXI_ID_WIDTH   = 10,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_USER_WIDTH = 10,
  parameter int MASTER_ID      = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  // native request side
  input  logic                        req_i,
  input  logic                        we_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
  input  logic [7:0]                  len_i,
  output logic                        gnt_o,
  input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] wbe_i,
  input  logic                        wvalid_i,
  output logic                        wready_o,
  output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
  output logic                        rvalid_o,
  output logic                        done_o,
  output logic                        err_o,
  // AW channel
  output logic [AXI_ID_WIDTH-1:0]     axi_aw_id,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr,
  output logic [7:0]                  axi_aw_len,
  output logic [2:0]                  axi_aw_size,
  output logic [1:0]                  axi_aw_burst,
  output logic                        axi_aw_lock,
  output logic [3:0]                  axi_aw_cache,
  output logic [2:0]                  axi_aw_prot,
  output logic [3:0]                  axi_aw_qos,
  output logic [3:0]                  axi_aw_region,
  output logic [AXI_USER_WIDTH-1:0]   axi_aw_user,
  output logic                        axi_aw_valid,
  input  logic                        axi_aw_ready,
  // W channel
  output logic [AXI_DATA_WIDTH-1:0]   axi_w_data,
  output logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb,
  output logic                        axi_w_last,
  output logic [AXI_USER_WIDTH-1:0]   axi_w_user,
  output logic                        axi_w_valid,
  input  logic                        axi_w_ready,
  // B channel
  input  logic [AXI_ID_WIDTH-1:0]     axi_b_id,
  input  logic [1:0]                  axi_b_resp,
  input  logic [AXI_USER_WIDTH-1:0]   axi_b_user,
  input  logic                        axi_b_valid,
  output logic                        axi_b_ready,
  // AR channel
  output logic [AXI_ID_WIDTH-1:0]     axi_ar_id,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_ar_addr,
  output logic [7:0]                  axi_ar_len,
  output logic [2:0]                  axi_ar_size,
  output logic [1:0]                  axi_ar_burst,
  output logic                        axi_ar_lock,
  output logic [3:0]                  axi_ar_cache,
  output logic [2:0]                  axi_ar_prot,
  output logic [3:0]                  axi_ar_qos,
  output logic [3:0]                  axi_ar_region,
  output logic [AXI_USER_WIDTH-1:0]   axi_ar_user,
  output logic                        axi_ar_valid,
  input  logic                        axi_ar_ready,
  // R channel
  input  logic [AXI_ID_WIDTH-1:0]     axi_r_id,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_r_data,
  input  logic [1:0]                  axi_r_resp,
  input  logic                        axi_r_last,
  input  logic [AXI_USER_WIDTH-1:0]   axi_r_user,
  input  logic                        axi_r_valid,
  output logic                        axi_r_ready
);

  localparam int NR_BYTES     = AXI_DATA_WIDTH / 8;
  localparam int LOG_NR_BYTES = $clog2(NR_BYTES);
  localparam logic [AXI_ADDR_WIDTH-1:0] LOW_MASK =
    AXI_ADDR_WIDTH'((64'd1 << LOG_NR_BYTES) - 64'd1);

`ifdef PERIPHERAL_MPRAM_AXI4_MASTER_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B} state_e;

  state_e                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]                len_q, len_d;
  logic [7:0]                cnt_q, cnt_d;
  logic                      err_q, err_d;
  // set once the read beat count has passed len_q; keeps rvalid_o suppressed
  // even if cnt_q wraps during a long run of surplus beats
  logic                      ovr_q, ovr_d;
  logic                      in_range;

  // response IDs/user and (in single-beat builds) len_i are intentionally ignored
  logic unused_sig;
  assign unused_sig = ^{axi_b_id, axi_b_user, axi_r_id, axi_r_user, len_i};

  // address-phase fields come straight from the captured registers
  assign axi_aw_id     = AXI_ID_WIDTH'(MASTER_ID);
  assign axi_aw_addr   = addr_q;
  assign axi_aw_len    = len_q;
  assign axi_aw_size   = 3'(LOG_NR_BYTES);
  assign axi_aw_burst  = 2'b01;
  assign axi_aw_lock   = 1'b0;
  assign axi_aw_cache  = '0;
  assign axi_aw_prot   = '0;
  assign axi_aw_qos    = '0;
  assign axi_aw_region = '0;
  assign axi_aw_user   = '0;
  assign axi_w_user    = '0;

  assign axi_ar_id     = AXI_ID_WIDTH'(MASTER_ID);
  assign axi_ar_addr   = addr_q;
  assign axi_ar_len    = len_q;
  assign axi_ar_size   = 3'(LOG_NR_BYTES);
  assign axi_ar_burst  = 2'b01;
  assign axi_ar_lock   = 1'b0;
  assign axi_ar_cache  = '0;
  assign axi_ar_prot   = '0;
  assign axi_ar_qos    = '0;
  assign axi_ar_region = '0;
  assign axi_ar_user   = '0;

  // a read beat is forwarded only while it falls inside the requested burst
  assign in_range = ~ovr_q & (cnt_q <= len_q);

  // state and transaction registers; async reset forces IDLE so valids drop at once
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  // next-state and all handshake/native outputs, decoded from the current state
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    ovr_d        = ovr_q;
    gnt_o        = 1'b0;
    wready_o     = 1'b0;
    rdata_o      = '0;
    rvalid_o     = 1'b0;
    done_o       = 1'b0;
    err_o        = 1'b0;
    axi_aw_valid = 1'b0;
    axi_ar_valid = 1'b0;
    axi_w_data   = '0;
    axi_w_strb   = '0;
    axi_w_last   = 1'b0;
    axi_w_valid  = 1'b0;
    axi_b_ready  = 1'b0;
    axi_r_ready  = 1'b0;

    unique case (state_q)
      IDLE: begin
        gnt_o = req_i;
        if (req_i) begin
          addr_d  = addr_i & ~LOW_MASK;
          len_d   = BURST_EN ? len_i : 8'd0;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
          ovr_d   = 1'b0;
          state_d = we_i ? AW : AR;
        end
      end

      AR: begin
        axi_ar_valid = 1'b1;
        if (axi_ar_ready) state_d = R;
      end

      R: begin
        axi_r_ready = 1'b1;
        if (axi_r_valid) begin
          rvalid_o = in_range;
          rdata_o  = in_range ? axi_r_data : '0;
          cnt_d    = cnt_q + 8'd1;
          if (cnt_q == len_q) ovr_d = 1'b1;
          err_d    = err_q | (axi_r_resp != 2'b00) | ~in_range;
          if (axi_r_last) begin
            // last arriving early or late is a protocol mismatch
            err_d   = err_d | (cnt_q != len_q) | ovr_q;
            done_o  = 1'b1;
            err_o   = err_d;
            state_d = IDLE;
          end
        end
      end

      AW: begin
        axi_aw_valid = 1'b1;
        if (axi_aw_ready) state_d = W;
      end

      W: begin
        axi_w_valid = wvalid_i;
        axi_w_data  = wdata_i;
        axi_w_strb  = wbe_i;
        axi_w_last  = (cnt_q == len_q);
        wready_o    = axi_w_ready;
        if (wvalid_i && axi_w_ready) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q) state_d = B;
        end
      end

      B: begin
        axi_b_ready = 1'b1;
        if (axi_b_valid) begin
          err_d   = err_q | (axi_b_resp != 2'b00);
          done_o  = 1'b1;
          err_o   = err_d;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_peripheral_mpram_axi4_master.sv
// Directed self-checking bench for peripheral_mpram_axi4_master.
// Inputs change just after the falling edge; outputs are checked 1 time unit
// later, well away from the rising edge that advances the design.
module tb_peripheral_mpram_axi4_master;

  localparam int IDW = 10;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int UW  = 10;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic req_i, we_i;
  logic [AW-1:0] addr_i;
  logic [7:0] len_i;
  logic gnt_o;
  logic [DW-1:0] wdata_i;
  logic [DW/8-1:0] wbe_i;
  logic wvalid_i, wready_o;
  logic [DW-1:0] rdata_o;
  logic rvalid_o, done_o, err_o;
  logic [IDW-1:0] aw_id, ar_id;
  logic [AW-1:0] aw_addr, ar_addr;
  logic [7:0] aw_len, ar_len;
  logic [2:0] aw_size, ar_size, aw_prot, ar_prot;
  logic [1:0] aw_burst, ar_burst;
  logic aw_lock, ar_lock;
  logic [3:0] aw_cache, ar_cache, aw_qos, ar_qos, aw_region, ar_region;
  logic [UW-1:0] aw_user, ar_user, w_user;
  logic aw_valid, aw_ready, ar_valid, ar_ready;
  logic [DW-1:0] w_data;
  logic [DW/8-1:0] w_strb;
  logic w_last, w_valid, w_ready;
  logic [IDW-1:0] b_id, r_id;
  logic [1:0] b_resp, r_resp;
  logic [UW-1:0] b_user, r_user;
  logic b_valid, b_ready;
  logic [DW-1:0] r_data;
  logic r_last, r_valid, r_ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  peripheral_mpram_axi4_master dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .len_i(len_i), .gnt_o(gnt_o),
    .wdata_i(wdata_i), .wbe_i(wbe_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .rdata_o(rdata_o), .rvalid_o(rvalid_o), .done_o(done_o), .err_o(err_o),
    .axi_aw_id(aw_id), .axi_aw_addr(aw_addr), .axi_aw_len(aw_len), .axi_aw_size(aw_size),
    .axi_aw_burst(aw_burst), .axi_aw_lock(aw_lock), .axi_aw_cache(aw_cache),
    .axi_aw_prot(aw_prot), .axi_aw_qos(aw_qos), .axi_aw_region(aw_region),
    .axi_aw_user(aw_user), .axi_aw_valid(aw_valid), .axi_aw_ready(aw_ready),
    .axi_w_data(w_data), .axi_w_strb(w_strb), .axi_w_last(w_last), .axi_w_user(w_user),
    .axi_w_valid(w_valid), .axi_w_ready(w_ready),
    .axi_b_id(b_id), .axi_b_resp(b_resp), .axi_b_user(b_user), .axi_b_valid(b_valid),
    .axi_b_ready(b_ready),
    .axi_ar_id(ar_id), .axi_ar_addr(ar_addr), .axi_ar_len(ar_len), .axi_ar_size(ar_size),
    .axi_ar_burst(ar_burst), .axi_ar_lock(ar_lock), .axi_ar_cache(ar_cache),
    .axi_ar_prot(ar_prot), .axi_ar_qos(ar_qos), .axi_ar_region(ar_region),
    .axi_ar_user(ar_user), .axi_ar_valid(ar_valid), .axi_ar_ready(ar_ready),
    .axi_r_id(r_id), .axi_r_data(r_data), .axi_r_resp(r_resp), .axi_r_last(r_last),
    .axi_r_user(r_user), .axi_r_valid(r_valid), .axi_r_ready(r_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // wait for the next falling edge, where new inputs are applied
  task automatic nxt();
    @(negedge clk_i);
  endtask

  initial begin
    rst_ni = 1'b0; req_i = 0; we_i = 0; addr_i = '0; len_i = '0;
    wdata_i = '0; wbe_i = '0; wvalid_i = 0;
    aw_ready = 0; w_ready = 0; ar_ready = 0;
    b_id = '0; b_resp = '0; b_user = '0; b_valid = 0;
    r_id = '0; r_data = '0; r_resp = '0; r_last = 0; r_user = '0; r_valid = 0;

    // ---- reset state
    nxt(); nxt(); #1;
    chk("rst_ar_valid", 64'(ar_valid), 0);
    chk("rst_aw_valid", 64'(aw_valid), 0);
    chk("rst_w_valid", 64'(w_valid), 0);
    chk("rst_readies", 64'({r_ready, b_ready}), 0);
    chk("rst_native", 64'({gnt_o, wready_o, rvalid_o, done_o, err_o}), 0);
    chk("rst_addr", ar_addr, 0);
    nxt(); rst_ni = 1'b1;

    // ---- single read at 0x1003, data 0xDEADBEEF
    nxt(); req_i = 1; we_i = 0; addr_i = 64'h1003; len_i = 0; #1;
    chk("rd_gnt", 64'(gnt_o), 1);
    nxt(); req_i = 0; #1;
    chk("rd_ar_valid", 64'(ar_valid), 1);
    chk("rd_ar_addr", ar_addr, 64'h1000);
    chk("rd_ar_len", 64'(ar_len), 0);
    chk("rd_ar_size_burst", 64'({ar_size, ar_burst}), 64'({3'd3, 2'b01}));
    chk("rd_gnt_busy", 64'(gnt_o), 0);
    ar_ready = 1;
    nxt(); ar_ready = 0; r_valid = 1; r_data = 64'hDEADBEEF; r_last = 1; r_resp = 0; #1;
    chk("rd_r_ready", 64'(r_ready), 1);
    chk("rd_rvalid", 64'(rvalid_o), 1);
    chk("rd_rdata", rdata_o, 64'hDEADBEEF);
    chk("rd_done_err", 64'({done_o, err_o}), 64'b10);
    nxt(); r_valid = 0; r_last = 0; #1;
    chk("rd_idle", 64'({done_o, ar_valid, r_ready}), 0);

    // ---- single write 0x55AA, be 0x0F, aw_ready delayed 3 cycles
    nxt(); req_i = 1; we_i = 1; addr_i = 64'h2005; len_i = 0;
    wvalid_i = 1; wdata_i = 64'h55AA; wbe_i = 8'h0F; #1;
    chk("wr_gnt", 64'(gnt_o), 1);
    for (int i = 0; i < 3; i++) begin
      nxt(); req_i = 0; #1;
      chk("wr_aw_hold_valid", 64'(aw_valid), 1);
      chk("wr_aw_hold_addr", aw_addr, 64'h2000);
      chk("wr_aw_hold_len", 64'(aw_len), 0);
      chk("wr_no_early_w", 64'({w_valid, wready_o}), 0);
    end
    nxt(); aw_ready = 1; #1;
    chk("wr_aw_valid_hs", 64'(aw_valid), 1);
    nxt(); aw_ready = 0; w_ready = 1; #1;
    chk("wr_aw_dropped", 64'(aw_valid), 0);
    chk("wr_w_valid", 64'(w_valid), 1);
    chk("wr_w_data", w_data, 64'h55AA);
    chk("wr_w_strb_last", 64'({w_strb, w_last}), 64'({8'h0F, 1'b1}));
    chk("wr_wready", 64'(wready_o), 1);
    nxt(); w_ready = 0; wvalid_i = 0; #1;
    chk("wr_b_wait", 64'({b_ready, done_o, w_valid}), 64'b100);
    nxt(); b_valid = 1; b_resp = 2'b00; #1;
    chk("wr_done_err", 64'({done_o, err_o}), 64'b10);
    nxt(); b_valid = 0; #1;
    chk("wr_idle", 64'({done_o, b_ready}), 0);

    // ---- write with SLVERR response
    nxt(); req_i = 1; we_i = 1; addr_i = 64'h3000; wvalid_i = 1; wdata_i = 64'h1; wbe_i = 8'hFF;
    nxt(); req_i = 0; aw_ready = 1;
    nxt(); aw_ready = 0; w_ready = 1;
    nxt(); w_ready = 0; wvalid_i = 0; b_valid = 1; b_resp = 2'b10; #1;
    chk("slverr_done_err", 64'({done_o, err_o}), 64'b11);
    nxt(); b_valid = 0; b_resp = 0;

`ifdef PERIPHERAL_MPRAM_AXI4_MASTER_BURST_EN
    // ---- 4-beat read with gaps between beats
    nxt(); req_i = 1; we_i = 0; addr_i = 64'h4000; len_i = 3;
    nxt(); req_i = 0; #1;
    chk("brd_ar_len", 64'(ar_len), 3);
    ar_ready = 1;
    nxt(); ar_ready = 0;
    for (int i = 0; i < 4; i++) begin
      nxt(); r_valid = 0; #1;
      chk("brd_gap_rvalid", 64'(rvalid_o), 0);
      nxt(); r_valid = 1; r_data = 64'(100 + i); r_last = (i == 3); #1;
      chk("brd_rvalid", 64'(rvalid_o), 1);
      chk("brd_rdata", rdata_o, 64'(100 + i));
      chk("brd_done", 64'({done_o, err_o}), (i == 3) ? 64'b10 : 64'b00);
    end
    nxt(); r_valid = 0; r_last = 0;

    // ---- read len 3, last arrives early on beat 2
    nxt(); req_i = 1; we_i = 0; addr_i = 64'h5000; len_i = 3;
    nxt(); req_i = 0; ar_ready = 1;
    nxt(); ar_ready = 0; r_valid = 1; r_data = 64'hA0; r_last = 0; #1;
    chk("early_b0_done", 64'(done_o), 0);
    nxt(); r_data = 64'hA1; r_last = 1; req_i = 1; we_i = 0; addr_i = 64'h6000; len_i = 0; #1;
    chk("early_rvalid", 64'(rvalid_o), 1);
`else
    // ---- len_i ignored: a 4-beat request becomes a single beat
    nxt(); req_i = 1; we_i = 0; addr_i = 64'h4000; len_i = 3;
    nxt(); req_i = 0; #1;
    chk("sb_ar_len", 64'(ar_len), 0);
    ar_ready = 1;
    nxt(); ar_ready = 0; r_valid = 1; r_data = 64'h77; r_last = 1; #1;
    chk("sb_rdata", rdata_o, 64'h77);
    chk("sb_done", 64'({done_o, err_o}), 64'b10);
    nxt(); r_valid = 0; r_last = 0;

    // ---- extra R beat: first beat without last, second beat with last
    nxt(); req_i = 1; we_i = 0; addr_i = 64'h5000; len_i = 0;
    nxt(); req_i = 0; ar_ready = 1;
    nxt(); ar_ready = 0; r_valid = 1; r_data = 64'hA0; r_last = 0; #1;
    chk("extra_b0_rvalid", 64'({rvalid_o, done_o}), 64'b10);
    nxt(); r_data = 64'hA1; r_last = 1; req_i = 1; we_i = 0; addr_i = 64'h6000; len_i = 0; #1;
    chk("extra_rvalid_supp", 64'(rvalid_o), 0);
`endif
    chk("mismatch_done_err", 64'({done_o, err_o}), 64'b11);
    chk("mismatch_no_gnt", 64'(gnt_o), 0);
    nxt(); r_valid = 0; r_last = 0; #1;
    chk("mismatch_gnt_next", 64'(gnt_o), 1);
    nxt(); req_i = 0; #1;
    chk("after_ar_valid", 64'(ar_valid), 1);
    ar_ready = 1;
    nxt(); ar_ready = 0; r_valid = 1; r_data = 64'h5; r_last = 1; #1;
    chk("after_done", 64'({done_o, err_o}), 64'b10);
    nxt(); r_valid = 0; r_last = 0;

    // ---- reset during W of a 4-beat write
    nxt(); req_i = 1; we_i = 1; addr_i = 64'h7000; len_i = 3; wvalid_i = 1; wdata_i = 64'hB0; wbe_i = 8'hFF;
    nxt(); req_i = 0; aw_ready = 1;
    nxt(); aw_ready = 0; w_ready = 1; #1;
`ifdef PERIPHERAL_MPRAM_AXI4_MASTER_BURST_EN
    chk("rw_w_last_b0", 64'(w_last), 0);
    nxt(); w_ready = 0; #1;
`else
    w_ready = 0; #1;
`endif
    chk("rw_in_w", 64'({w_valid, wready_o}), 64'b10);
    rst_ni = 1'b0; #1;
    chk("rw_rst_valids", 64'({aw_valid, ar_valid, w_valid, r_ready, b_ready}), 0);
    chk("rw_rst_native", 64'({wready_o, done_o, gnt_o}), 0);
    nxt(); wvalid_i = 0; rst_ni = 1'b1; req_i = 1; we_i = 0; addr_i = 64'h8000; len_i = 0; #1;
    chk("rw_post_gnt", 64'(gnt_o), 1);
    nxt(); req_i = 0; #1;
    chk("rw_post_ar", ar_addr, 64'h8000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/peripheral_mpram_axi4_master.md
# peripheral_mpram_axi4_master

AXI4 manager that turns a native single-outstanding memory request port into AXI4 INCR transactions, one transaction at a time. It sits between a local requester (DMA, test driver, CPU port) and the MPRAM AXI4 slave or any AXI4 subordinate. It generates AR/R or AW/W/B sequences and returns read data, write completion and error status on the native side.

## Interface
- AXI_ID_WIDTH, 10: ID width.
- AXI_ADDR_WIDTH, 64: address width.
- AXI_DATA_WIDTH, 64: data width. Byte lanes = AXI_DATA_WIDTH/8; LOG_NR_BYTES = $clog2 of that.
- AXI_USER_WIDTH, 10: user width.
- MASTER_ID, 0: constant driven on axi_aw_id and axi_ar_id.
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_ni  in  1  asynchronous reset, active-low.
- req_i  in  1  transaction request.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  AXI_ADDR_WIDTH  start byte address.
- len_i  in  8  beats-1.
- gnt_o  out  1  request accepted. Combinational; only ever high in IDLE.
- wdata_i, wbe_i, wvalid_i  in  DATA, DATA/8, 1  write beat.
- wready_o  out  1  write beat consumed.
- rdata_o, rvalid_o  out  DATA, 1  read beat. No backpressure.
- done_o  out  1  one-cycle pulse at transaction end.
- err_o  out  1  valid with done_o; 1 = any non-OKAY response or protocol mismatch.
- axi_aw_{id,addr,len,size,burst,valid}  out; axi_aw_ready in.
- axi_aw_{lock,cache,prot,qos,region,user}  out  tied 0.
- axi_w_{data,strb,last,valid}  out; axi_w_ready in; axi_w_user out, tied 0.
- axi_b_{id,resp,user,valid}  in; axi_b_ready out.
- axi_ar_* mirror axi_aw_* in both direction and tie-offs.
- axi_r_{id,data,resp,last,user,valid}  in; axi_r_ready out.

## Operation
- Registers: state, addr_q, len_q, cnt_q (8 bit), err_q.
- States: IDLE, AR, R, AW, W, B.
- IDLE:
  - gnt_o = req_i.
  - On req_i, capture addr_i with its low LOG_NR_BYTES bits cleared, capture len_i, clear cnt_q and err_q.
  - Next state is AW if we_i = 1, else AR.
- AR / AW:
  - Assert axi_ar_valid / axi_aw_valid with addr_q, len_q, size = LOG_NR_BYTES, burst = INCR (2'b01).
  - Hold all fields stable until the matching ready is high.
  - AR goes to R on handshake; AW goes to W on handshake.
- R:
  - axi_r_ready = 1.
  - Each axi_r_valid beat: rdata_o = axi_r_data and rvalid_o = 1 (combinational pass-through) while cnt_q <= len_q; cnt_q increments; err_q |= (axi_r_resp != 0).
  - On the beat with axi_r_last = 1: err_q also sets if cnt_q != len_q. Then pulse done_o and return to IDLE.
  - Beats beyond len_q without last: rvalid_o is suppressed, err_q sets, and the block keeps accepting beats until last.
- W:
  - axi_w_valid = wvalid_i, axi_w_data = wdata_i, axi_w_strb = wbe_i.
  - axi_w_last = (cnt_q == len_q); wready_o = axi_w_ready.
  - cnt_q increments on each handshake; the last handshake moves to B.
- B:
  - axi_b_ready = 1.
  - On axi_b_valid: err_q |= (axi_b_resp != 0), pulse done_o with err_o = final err, go to IDLE.
- Caller's responsibility: no 4 KB boundary crossing. The block does not split bursts.
- Response IDs are not checked.

## Timing
- Reset values:
  - All AXI valid outputs 0; axi_r_ready and axi_b_ready 0.
  - gnt_o, wready_o, rvalid_o, done_o, err_o 0.
  - Address and data outputs 0; state IDLE.
- Latency:
  - Grant cycle N, then axi_ar_valid / axi_aw_valid asserted at N+1.
  - Single-beat read: done_o in the same cycle as the R handshake.
  - Single-beat write: done_o in the same cycle as the B handshake.
- No new gnt_o until the cycle after done_o. A req_i held during a busy period is granted then.
- W data is never presented before the AW handshake completes.
- Reset mid-transaction: state returns to IDLE asynchronously and all valid/ready outputs drop immediately. Protocol recovery of the subordinate is the system's responsibility.

## Configuration
- PERIPHERAL_MPRAM_AXI4_MASTER_BURST_EN:
  - Defined: len_i is honoured (1-256 beats).
  - Undefined: len_i is ignored; axi_*_len = 0, axi_w_last = 1 on every beat, and every transaction is single-beat. The cnt_q mismatch check still applies, so an extra R beat sets err_o.

## Test plan
- Single read at addr 0x1003, subordinate returns 0xDEADBEEF, OKAY. Required: axi_ar_addr = 0x1000, axi_ar_len = 0, rvalid_o with 0xDEADBEEF, done_o = 1, err_o = 0.
- Single write 0x55AA, wbe_i = 0x0F, aw_ready delayed 3 cycles. Required: AW fields held stable, axi_w_valid only after the AW handshake, w_last = 1, done_o on B, err_o = 0.
- BURST_EN, 4-beat read (len_i = 3), r_valid gapped. Required: 4 rvalid_o pulses in order, done_o on the 4th beat.
- Write with b_resp = SLVERR (2'b10). Required: done_o with err_o = 1.
- Read where the subordinate asserts r_last on beat 2 of len 3. Required: done_o with err_o = 1, back to IDLE, next req_i granted the cycle after done_o.
- rst_ni asserted during W of a 4-beat write. Required: all valids 0 immediately, IDLE, and a new request is granted after reset is released.
